multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_pkg.sv | 48 ++++
 rtl/instr_decoder.sv | 62 ++++++
 rtl/multicycle_ctrl.sv | 116 +++++++++++
 tb/tb_multicycle_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode/funct encodings, ALU codes, FSM states and decoded-instruction record
// for the multicycle controller.
package ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpHalt  = 6'h3F;

  localparam logic [5:0] FunctAnd = 6'h24;
  localparam logic [5:0] FunctOr  = 6'h25;
  localparam logic [5:0] FunctAdd = 6'h20;
  localparam logic [5:0] FunctSub = 6'h22;
  localparam logic [5:0] FunctSlt = 6'h2A;
  localparam logic [5:0] FunctNor = 6'h27;

  localparam logic [3:0] AluAnd = 4'd0;
  localparam logic [3:0] AluOr  = 4'd1;
  localparam logic [3:0] AluAdd = 4'd2;
  localparam logic [3:0] AluSub = 4'd6;
  localparam logic [3:0] AluSlt = 4'd7;
  localparam logic [3:0] AluNor = 4'd12;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb,
    StHalt,
    StTrap
  } state_e;

  typedef struct packed {
    logic [4:0]  ina;
    logic [4:0]  inb;
    logic [4:0]  inc;
    logic [15:0] ind;
    logic [3:0]  control;
    logic        controll;
    logic        is_halt;
    logic        is_valid;
    logic        ovf_checked;
  } decode_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: maps a 32-bit instruction word onto register
// addresses, immediate, ALU code and classification flags.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0] ir_i,
  output decode_t     dec_o
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = ir_i[31:26];
  assign funct  = ir_i[5:0];

  always_comb begin
    dec_o          = '0;
    dec_o.ina      = ir_i[25:21];
    dec_o.inb      = ir_i[20:16];
    dec_o.ind      = ir_i[15:0];
    dec_o.inc      = ir_i[15:11];
    dec_o.is_valid = 1'b1;
    case (opcode)
      OpRtype: begin
        case (funct)
          FunctAnd: dec_o.control = AluAnd;
          FunctOr:  dec_o.control = AluOr;
          FunctAdd: begin
            dec_o.control     = AluAdd;
            dec_o.ovf_checked = 1'b1;
          end
          FunctSub: begin
            dec_o.control     = AluSub;
            dec_o.ovf_checked = 1'b1;
          end
          FunctSlt: dec_o.control = AluSlt;
          FunctNor: dec_o.control = AluNor;
          default:  dec_o.is_valid = 1'b0;
        endcase
      end
      OpAddi, OpAndi, OpOri, OpSlti: begin
        dec_o.inc      = ir_i[20:16];
        dec_o.controll = 1'b1;
        case (opcode)
          OpAddi: begin
            dec_o.control     = AluAdd;
            dec_o.ovf_checked = 1'b1;
          end
          OpAndi:  dec_o.control = AluAnd;
          OpOri:   dec_o.control = AluOr;
          default: dec_o.control = AluSlt;
        endcase
      end
      OpHalt: begin
        dec_o.is_halt  = 1'b1;
        dec_o.is_valid = 1'b0;
      end
      default: dec_o.is_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle fetch/decode/execute/writeback controller with registered datapath controls.
// Define OVF_TRAP_EN to trap on signed overflow of ADD/SUB/ADDI instead of writing back.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned      PC_W     = 8,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_data,
  output logic [4:0]      inA,
  output logic [4:0]      inB,
  output logic [4:0]      inC,
  output logic [15:0]     inD,
  output logic [3:0]      control,
  output logic            controll,
  output logic            reg_we,
  input  logic            overflow,
  output logic            busy,
  output logic            halted,
  output logic            trap
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  decode_t         dec_q, dec_d;
  logic            reg_we_q, reg_we_d;
  logic            wb_we;

  // Decoding ir_d keeps dec_q in lock-step with ir_q, so controls are valid from DECODE on.
  instr_decoder u_instr_decoder (
    .ir_i  (ir_d),
    .dec_o (dec_d)
  );

  assign wb_we = dec_q.is_valid && (dec_q.inc != 5'd0);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    reg_we_d = 1'b0;
    unique case (state_q)
      StIdle: if (start) state_d = StFetch;
      StFetch: begin
        if (imem_valid) begin
          ir_d    = imem_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = StDecode;
        end
      end
      StDecode: state_d = dec_q.is_halt ? StHalt : StExec;
      StExec: begin
`ifdef OVF_TRAP_EN
        if (overflow && dec_q.ovf_checked) begin
          state_d = StTrap;
        end else begin
          state_d  = StWb;
          reg_we_d = wb_we;
        end
`else
        state_d  = StWb;
        reg_we_d = wb_we;
`endif
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      StTrap:  state_d = StTrap;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      dec_q    <= '0;
      reg_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      dec_q    <= dec_d;
      reg_we_q <= reg_we_d;
    end
  end

  assign imem_req  = (state_q == StFetch);
  assign imem_addr = imem_req ? pc_q : '0;
  assign inA       = dec_q.ina;
  assign inB       = dec_q.inb;
  assign inC       = dec_q.inc;
  assign inD       = dec_q.ind;
  assign control   = dec_q.control;
  assign controll  = dec_q.controll;
  assign reg_we    = reg_we_q;
  assign busy      = (state_q == StFetch) || (state_q == StDecode) ||
                     (state_q == StExec)  || (state_q == StWb);
  assign halted    = (state_q == StHalt);

`ifdef OVF_TRAP_EN
  assign trap = (state_q == StTrap);
`else
  logic unused_ovf;
  assign unused_ovf = ^{overflow, dec_q.ovf_checked};
  assign trap       = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random instruction
// streams checked against an instruction-level reference model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, imem_valid, overflow;
  logic [31:0] imem_data;
  logic        imem_req, controll, reg_we, busy, halted, trap;
  logic [7:0]  imem_addr;
  logic [4:0]  inA, inB, inC;
  logic [15:0] inD;
  logic [3:0]  control;

  int errors = 0;
  int checks = 0;
  int exp_pc = 0;

  multicycle_ctrl #(.PC_W(8), .RESET_PC(8'd0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .inA        (inA),
    .inB        (inB),
    .inC        (inC),
    .inD        (inD),
    .control    (control),
    .controll   (controll),
    .reg_we     (reg_we),
    .overflow   (overflow),
    .busy       (busy),
    .halted     (halted),
    .trap       (trap)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level model: ALU code, operand kind and overflow relevance from the op tables.
  function automatic void model(input logic [31:0] ir, output bit known, output bit is_r,
                                output logic [3:0] alu, output bit ovfc);
    logic [5:0] op;
    logic [5:0] fn;
    op = ir[31:26];
    fn = ir[5:0];
    known = 1'b1;
    is_r  = (op == 6'h00);
    alu   = 4'd0;
    ovfc  = 1'b0;
    if (is_r) begin
      case (fn)
        6'h24: alu = 4'd0;
        6'h25: alu = 4'd1;
        6'h20: begin alu = 4'd2; ovfc = 1'b1; end
        6'h22: begin alu = 4'd6; ovfc = 1'b1; end
        6'h2A: alu = 4'd7;
        6'h27: alu = 4'd12;
        default: known = 1'b0;
      endcase
    end else begin
      case (op)
        6'h08: begin alu = 4'd2; ovfc = 1'b1; end
        6'h0C: alu = 4'd0;
        6'h0D: alu = 4'd1;
        6'h0A: alu = 4'd7;
        default: known = 1'b0;
      endcase
    end
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ir;
    ir = $urandom;
    case ($urandom_range(0, 4))
      0, 1: begin
        ir[31:26] = 6'h00;
        case ($urandom_range(0, 5))
          0: ir[5:0] = 6'h24;
          1: ir[5:0] = 6'h25;
          2: ir[5:0] = 6'h20;
          3: ir[5:0] = 6'h22;
          4: ir[5:0] = 6'h2A;
          default: ir[5:0] = 6'h27;
        endcase
        if ($urandom_range(0, 7) == 0) ir[15:11] = 5'd0;
      end
      2: begin
        case ($urandom_range(0, 3))
          0: ir[31:26] = 6'h08;
          1: ir[31:26] = 6'h0C;
          2: ir[31:26] = 6'h0D;
          default: ir[31:26] = 6'h0A;
        endcase
      end
      3: ir[31:26] = ($urandom_range(0, 1) == 0) ? 6'h3E : (6'h10 + 6'($urandom_range(0, 7)));
      default: begin
        ir[31:26] = 6'h00;
        ir[5:0]   = 6'h21;
      end
    endcase
    return ir;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; imem_valid = 1'b0; overflow = 1'b0; imem_data = '0;
    step();
    step();
    rst_n  = 1'b1;
    exp_pc = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Entry: DUT expected in FETCH. Runs one instruction through to the next FETCH or a terminal state.
  task automatic run_instr(input logic [31:0] ir, input int delay, input bit ovf);
    bit         known, is_r, ovfc, exp_trap;
    logic [3:0] alu;
    logic [4:0] exp_c;
    model(ir, known, is_r, alu, ovfc);
    exp_c = is_r ? ir[15:11] : ir[20:16];
`ifdef OVF_TRAP_EN
    exp_trap = ovf && ovfc && known;
`else
    exp_trap = 1'b0;
`endif
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'(exp_pc) || reg_we !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fetch_entry: req=%b addr=%0d we=%b busy=%b, required req=1 addr=%0d we=0 busy=1",
               imem_req, imem_addr, reg_we, busy, exp_pc);
    end
    imem_valid = 1'b0;
    for (int d = 0; d < delay; d++) begin
      step();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'(exp_pc)) begin
        errors++;
        $display("FAIL fetch_hold: cycle %0d req=%b addr=%0d, required req=1 addr=%0d",
                 d, imem_req, imem_addr, exp_pc);
      end
    end
    imem_valid = 1'b1;
    imem_data  = ir;
    step();
    imem_valid = 1'b0;
    imem_data  = $urandom;
    exp_pc     = (exp_pc + 1) % 256;
    for (int c = 0; c < 2; c++) begin
      if (c == 1 && (ir[31:26] == 6'h3F)) break;
      checks++;
      if (inA !== ir[25:21] || inB !== ir[20:16] || inD !== ir[15:0] || imem_req !== 1'b0 ||
          reg_we !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL operands_c%0d: A=%0d B=%0d D=%h req=%b we=%b busy=%b, required A=%0d B=%0d D=%h req=0 we=0 busy=1",
                 c, inA, inB, inD, imem_req, reg_we, busy, ir[25:21], ir[20:16], ir[15:0]);
      end
      if (known) begin
        checks++;
        if (inC !== exp_c || control !== alu || controll !== !is_r) begin
          errors++;
          $display("FAIL ctrl_c%0d ir=%h: C=%0d alu=%0d imm=%b, required C=%0d alu=%0d imm=%b",
                   c, ir, inC, control, controll, exp_c, alu, !is_r);
        end
      end
      if (c == 0) begin
        step();
        overflow = ovf;
      end
    end
    if (ir[31:26] == 6'h3F) begin
      step();
      checks++;
      if (halted !== 1'b1 || busy !== 1'b0 || reg_we !== 1'b0) begin
        errors++;
        $display("FAIL halt_entry: halted=%b busy=%b we=%b, required 1 0 0", halted, busy, reg_we);
      end
      return;
    end
    step();
    overflow = 1'b0;
    if (exp_trap) begin
      checks++;
      if (trap !== 1'b1 || reg_we !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL trap_entry: trap=%b we=%b busy=%b, required 1 0 0", trap, reg_we, busy);
      end
      return;
    end
    checks++;
    if (reg_we !== (known && exp_c != 5'd0) || trap !== 1'b0 || busy !== 1'b1 ||
        (known && (inC !== exp_c || control !== alu))) begin
      errors++;
      $display("FAIL writeback ir=%h: we=%b trap=%b busy=%b C=%0d alu=%0d, required we=%b trap=0 busy=1",
               ir, reg_we, trap, busy, inC, control, known && exp_c != 5'd0);
    end
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({imem_req, imem_addr, inA, inB, inC, inD, control, controll, reg_we, busy, halted, trap}
        !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b addr=%0d A=%0d B=%0d C=%0d D=%h alu=%0d imm=%b we=%b busy=%b halted=%b trap=%b, required all 0",
               imem_req, imem_addr, inA, inB, inC, inD, control, controll, reg_we, busy, halted, trap);
    end
    step();
    checks++;
    if (imem_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_without_start: req=%b busy=%b, required 0 0", imem_req, busy);
    end
  endtask

  task automatic test_add_addi();
    do_reset();
    do_start();
    run_instr(32'h0022_1820, 0, 1'b0);
    run_instr(32'h2043_0005, 1, 1'b0);
  endtask

  task automatic test_fetch_stall();
    run_instr(32'h0022_1825, 4, 1'b0);
  endtask

  task automatic test_r0_and_unknown();
    run_instr(32'h0022_0020, 0, 1'b0);
    run_instr(32'hF800_0000 | 32'h0022_1820, 2, 1'b0);
    run_instr(32'h0022_1821, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit ovf = 1'b0;
`ifndef OVF_TRAP_EN
      ovf = ($urandom_range(0, 3) == 0);
`endif
      run_instr(rand_instr(), int'($urandom_range(0, 3)), ovf);
    end
  endtask

  task automatic test_wrap_and_halt();
    do_reset();
    do_start();
    for (int i = 0; i < 256; i++) run_instr(rand_instr(), int'($urandom_range(0, 1)), 1'b0);
    run_instr(32'hFC00_0000, 0, 1'b0);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (halted !== 1'b1 || busy !== 1'b0 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL halt_sticky: halted=%b busy=%b req=%b, required 1 0 0", halted, busy, imem_req);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    do_start();
    run_instr(32'h0022_1822, 0, 1'b1);
`ifndef OVF_TRAP_EN
    run_instr(32'h2043_7FFF, 0, 1'b1);
`endif
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    do_start();
    step();
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_pending: req=%b, required 1", imem_req);
    end
    imem_valid = 1'b1;
    imem_data  = 32'h0022_1820;
    rst_n      = 1'b0;
    step();
    imem_valid = 1'b0;
    rst_n      = 1'b1;
    checks++;
    if (imem_req !== 1'b0 || busy !== 1'b0 || inC !== 5'd0 || control !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_fetch: req=%b busy=%b C=%0d alu=%0d, required 0 0 0 0",
               imem_req, busy, inC, control);
    end
    step();
    step();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: req=%b, required 0", imem_req);
    end
    exp_pc = 0;
    do_start();
    run_instr(32'h3044_00FF, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add_addi();
    test_fetch_stall();
    test_r0_and_unknown();
    test_random();
    test_wrap_and_halt();
    test_overflow();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
